// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front end: size encodings, FSM states
// and the default implemented memory size.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MEM_BYTES_DEFAULT = 100;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// mem_lane_merge: store-data merge into the read word and load extract/extend
// from the low lanes. Halfword paths exist only with MEM_ACCESS_HALF_EN.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] rd_q,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  always_comb begin
    merged = wdata;
    loaded = rd_q;
    case (size)
      SZ_BYTE: begin
        merged = {rd_q[31:8], wdata[7:0]};
        loaded = {{24{sgn & rd_q[7]}}, rd_q[7:0]};
      end
`ifdef MEM_ACCESS_HALF_EN
      SZ_HALF: begin
        merged = {rd_q[31:16], wdata[15:0]};
        loaded = {{16{sgn & rd_q[15]}}, rd_q[15:0]};
      end
`endif
      default: begin
        merged = wdata;
        loaded = rd_q;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a combinational-read, sequential-write byte memory.
// Define MEM_ACCESS_HALF_EN to support halfword accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BYTE_SIZE  = 4,
  parameter int MEM_BYTES  = MEM_BYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);

  state_t                state_reg, state_next;
  logic                  we_reg, signed_reg, err_reg;
  logic [1:0]            size_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg, rd_q, merged, loaded;
  logic                  req_err, accept, sub_store;

  // Every access touches a full BYTE_SIZE window, so the last byte must be in range.
  always_comb begin
    req_err = (32'(req_addr) + 32'(BYTE_SIZE - 1)) > 32'(MEM_BYTES - 1);
    case (req_size)
      SZ_BYTE: ;
`ifdef MEM_ACCESS_HALF_EN
      SZ_HALF: if (req_addr[0]) req_err = 1'b1;
`endif
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  assign accept    = req_valid && (state_reg == IDLE);
  assign sub_store = we_reg && (size_reg != SZ_WORD);

  mem_lane_merge u_lane (
    .size   (size_reg),
    .sgn    (signed_reg),
    .rd_q   (rd_q),
    .wdata  (wdata_reg),
    .merged (merged),
    .loaded (loaded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      size_reg   <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rd_q       <= '0;
    end else begin
      if (accept) begin
        we_reg     <= req_we;
        signed_reg <= req_signed;
        err_reg    <= req_err;
        size_reg   <= req_size;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
      if (state_reg == ACCESS) rd_q <= mem_rd;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = addr_reg;
        if (we_reg && !sub_store) begin
          mem_we = 1'b1;
          mem_wd = wdata_reg;
        end
        state_next = sub_store ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr   = addr_reg;
        mem_we     = 1'b1;
        mem_wd     = merged;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_reg;
        if (!err_reg && !we_reg) rsp_rdata = loaded;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
